// File: rtl/core_run_ctrl_pkg.sv
// Shared types and defaults for the core management slice: run-state
// encoding, default core count, drain timeout and boot PC.
package core_manage_types;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2,
        RESUME = 2'd3
    } run_state_t;

    localparam int          NUM_CPUS          = 2;
    localparam int          DEF_DRAIN_TIMEOUT = 16;
    localparam logic [31:0] DEF_BOOT_PC       = 32'h0000_0000;

endpackage

// File: rtl/core_run_fsm.sv
// Single-core run/halt sequencer: stalls fetch, waits for the pipeline to
// drain (or times out), parks, then redirects to the saved PC on resume.
module core_run_fsm
    import core_manage_types::*;
#(
    parameter int               XLEN          = 32,
    parameter int               DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT,
    parameter logic [XLEN-1:0]  BOOT_PC       = XLEN'(DEF_BOOT_PC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            halt_req,
    input  logic            pipe_idle,
    input  logic [XLEN-1:0] commit_pc,
    input  logic            err_clr,
    output logic            fetch_stall,
    output logic            flush,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            halted,
    output logic            drain_err
);

    localparam int             CW       = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DRAIN_TIMEOUT - 1);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(DRAIN_TIMEOUT);

    run_state_t      state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [XLEN-1:0] saved_pc, saved_pc_nxt;
    logic            err_nxt, flush_nxt, timeout;

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = '0;
        saved_pc_nxt = saved_pc;
        flush_nxt    = 1'b0;
        timeout      = 1'b0;

        unique case (state)
            RUN: begin
                if (halt_req) state_nxt = DRAIN;
            end
            DRAIN: begin
                cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
                if (pipe_idle) begin
                    saved_pc_nxt = commit_pc;
                    state_nxt    = HALTED;
                end else if (cnt == CNT_LAST) begin
                    saved_pc_nxt = commit_pc;
                    flush_nxt    = 1'b1;
                    timeout      = 1'b1;
                    state_nxt    = HALTED;
                end
            end
            HALTED: begin
                if (!halt_req) begin
                    flush_nxt = 1'b1;
                    state_nxt = RESUME;
                end
            end
            RESUME: begin
                state_nxt = RUN;
            end
            default: state_nxt = HALTED;
        endcase

        // A timeout in the same cycle as err_clr must still leave the flag set.
        if (timeout)      err_nxt = 1'b1;
        else if (err_clr) err_nxt = 1'b0;
        else              err_nxt = drain_err;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= HALTED;
            cnt            <= '0;
            saved_pc       <= BOOT_PC;
            drain_err      <= 1'b0;
            flush          <= 1'b0;
            fetch_stall    <= 1'b1;
            halted         <= 1'b1;
            redirect_valid <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            saved_pc       <= saved_pc_nxt;
            drain_err      <= err_nxt;
            flush          <= flush_nxt;
            fetch_stall    <= (state_nxt != RUN);
            halted         <= (state_nxt == HALTED);
            redirect_valid <= (state_nxt == RESUME);
        end
    end

    assign redirect_pc = saved_pc;

endmodule

// File: rtl/core_run_ctrl.sv
// Per-core run/halt sequencer array: one independent core_run_fsm per core,
// with the PC buses sliced XLEN bits per core.
module core_run_ctrl #(
    parameter int                NUM_CPUS      = core_manage_types::NUM_CPUS,
    parameter int                XLEN          = 32,
    parameter int                DRAIN_TIMEOUT = core_manage_types::DEF_DRAIN_TIMEOUT,
    parameter logic [XLEN-1:0]   BOOT_PC       = XLEN'(core_manage_types::DEF_BOOT_PC)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CPUS-1:0]      halt_req,
    input  logic [NUM_CPUS-1:0]      pipe_idle,
    input  logic [NUM_CPUS*XLEN-1:0] commit_pc,
    input  logic [NUM_CPUS-1:0]      err_clr,
    output logic [NUM_CPUS-1:0]      fetch_stall,
    output logic [NUM_CPUS-1:0]      flush,
    output logic [NUM_CPUS-1:0]      redirect_valid,
    output logic [NUM_CPUS*XLEN-1:0] redirect_pc,
    output logic [NUM_CPUS-1:0]      halted,
    output logic [NUM_CPUS-1:0]      drain_err
);

    for (genvar i = 0; i < NUM_CPUS; i++) begin : g_core
        core_run_fsm #(
            .XLEN          (XLEN),
            .DRAIN_TIMEOUT (DRAIN_TIMEOUT),
            .BOOT_PC       (BOOT_PC)
        ) u_fsm (
            .clk            (clk),
            .rst            (rst),
            .halt_req       (halt_req[i]),
            .pipe_idle      (pipe_idle[i]),
            .commit_pc      (commit_pc[i*XLEN +: XLEN]),
            .err_clr        (err_clr[i]),
            .fetch_stall    (fetch_stall[i]),
            .flush          (flush[i]),
            .redirect_valid (redirect_valid[i]),
            .redirect_pc    (redirect_pc[i*XLEN +: XLEN]),
            .halted         (halted[i]),
            .drain_err      (drain_err[i])
        );
    end

endmodule
